// File: rtl/sd_sector_reader.sv
// sd_sector_reader: reads one 512-byte SD sector over SPI (CMD17) through a byte-exchange engine.
module sd_sector_reader #(
  parameter int R1_POLL    = 8,
  parameter int TOKEN_POLL = 4096
) (
  input  logic        cck,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] lba,
  input  logic        sdhc,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rx,
  output logic        cs_assert,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);
  localparam int CW = $clog2(TOKEN_POLL + R1_POLL + 512);
  typedef enum logic [2:0] {IDLE, CMD, R1, TOKEN, DATA, CRC, TAIL, FIN} state_t;
  state_t state, state_n;
  logic [31:0]   addr;
  logic [CW-1:0] cnt;
  logic [1:0]    err_n;
  logic          pend, ack, start_n;
  // pend marks an exchange in flight; a done pulse without one is dropped
  assign ack     = xfer_done & pend;
  assign busy    = state != IDLE;
  assign done    = state == FIN;
  assign start_n = (state == IDLE && go) || (ack && state_n != FIN);
  assign xfer_tx = state != CMD      ? 8'hFF :
                   cnt[2:0] == 3'd0  ? 8'h51 :
                   cnt[2:0] == 3'd1  ? addr[31:24] :
                   cnt[2:0] == 3'd2  ? addr[23:16] :
                   cnt[2:0] == 3'd3  ? addr[15:8] :
                   cnt[2:0] == 3'd4  ? addr[7:0] : 8'hFF;
  always_comb begin
    state_n = state;
    err_n   = err;
    case (state)
      IDLE:  if (go) begin
        state_n = CMD;
        err_n   = 2'b00;
      end
      CMD:   if (ack && cnt == CW'(5)) state_n = R1;
      R1:    if (ack) begin
        if (xfer_rx == 8'h00) state_n = TOKEN;
        else if (!xfer_rx[7]) begin
          state_n = TAIL;
          err_n   = 2'b10;
        end else if (cnt == CW'(R1_POLL - 1)) begin
          state_n = TAIL;
          err_n   = 2'b01;
        end
      end
      TOKEN: if (ack) begin
        if (xfer_rx == 8'hFE) state_n = DATA;
        else if (xfer_rx != 8'hFF || cnt == CW'(TOKEN_POLL - 1)) begin
          state_n = TAIL;
          err_n   = 2'b11;
        end
      end
      DATA:  if (ack && cnt == CW'(511)) state_n = CRC;
      CRC:   if (ack && cnt == CW'(1)) state_n = TAIL;
      TAIL:  if (ack) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge cck or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      err        <= 2'b00;
      cnt        <= '0;
      pend       <= 1'b0;
      xfer_start <= 1'b0;
      addr       <= '0;
      cs_assert  <= 1'b0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
    end else begin
      state      <= state_n;
      err        <= err_n;
      xfer_start <= start_n;
      pend       <= start_n | (pend & ~xfer_done);
      cnt        <= state_n != state ? '0 : ack ? cnt + 1'b1 : cnt;
      buf_we     <= ack && state == DATA;
      if (ack && state == DATA) begin
        buf_addr <= cnt[8:0];
        buf_data <= xfer_rx;
      end
      if (state == IDLE && go) begin
        addr      <= sdhc ? lba : lba << 9;
        cs_assert <= 1'b1;
      end else if (ack && state == TAIL) cs_assert <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sd_sector_reader.sv
// tb_sd_sector_reader: randomized SD sector read bench with a byte-engine model and scoreboard.
module tb_sd_sector_reader;
  localparam int R1P = 8;
  localparam int TKP = 4096;
  logic        cck = 1'b0, reset = 1'b1, go = 1'b0, sdhc = 1'b0, xfer_done = 1'b0;
  logic [31:0] lba = '0;
  logic [7:0]  xfer_rx = '0;
  logic        xfer_start, cs_assert, buf_we, busy, done;
  logic [7:0]  xfer_tx, buf_data;
  logic [8:0]  buf_addr;
  logic [1:0]  err;
  int checks = 0, fails = 0, dones = 0;
  int abort_at = -1;
  bit aborted = 1'b0;
  logic [1:0] last_err;
  logic [7:0]  exp_tx[$], rx_q[$];
  logic [16:0] exp_wr[$];
  logic [1:0]  exp_err[$];

  sd_sector_reader #(.R1_POLL(R1P), .TOKEN_POLL(TKP)) dut (
    .cck(cck), .reset(reset), .go(go), .lba(lba), .sdhc(sdhc),
    .xfer_start(xfer_start), .xfer_tx(xfer_tx), .xfer_done(xfer_done), .xfer_rx(xfer_rx),
    .cs_assert(cs_assert), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 cck = ~cck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_xfer_start"}, xfer_start, 0);
    check({tag, "_xfer_tx"}, xfer_tx, 8'hFF);
    check({tag, "_cs"}, cs_assert, 0);
    check({tag, "_buf_we"}, buf_we, 0);
    check({tag, "_buf_addr"}, buf_addr, 0);
    check({tag, "_buf_data"}, buf_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Reference model: card replies per phase and the expected bus traffic they imply
  task automatic build(input logic [31:0] l, input logic s, input int r1ff, input logic [7:0] r1v,
                       input int tkff, input logic [7:0] tkv, input bit rnd);
    logic [31:0] a;
    logic [7:0]  d;
    logic [1:0]  e;
    a = s ? l : l * 32'd512;
    exp_tx.delete(); rx_q.delete(); exp_wr.delete();
    exp_tx.push_back(8'h51); exp_tx.push_back(a[31:24]); exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]); exp_tx.push_back(a[7:0]); exp_tx.push_back(8'hFF);
    for (int i = 0; i < 6; i++) rx_q.push_back(8'($urandom));
    for (int i = 0; i < r1ff && i < R1P; i++) rx_q.push_back(8'hFF);
    if (r1ff >= R1P) e = 2'b01;
    else begin
      rx_q.push_back(r1v);
      if (r1v != 8'h00) e = 2'b10;
      else begin
        for (int i = 0; i < tkff && i < TKP; i++) rx_q.push_back(8'hFF);
        if (tkff >= TKP) e = 2'b11;
        else begin
          rx_q.push_back(tkv);
          if (tkv != 8'hFE) e = 2'b11;
          else begin
            e = 2'b00;
            for (int i = 0; i < 512; i++) begin
              d = rnd ? 8'($urandom) : 8'(i);
              rx_q.push_back(d);
              exp_wr.push_back({9'(i), d});
            end
            rx_q.push_back(8'($urandom)); rx_q.push_back(8'($urandom));
          end
        end
      end
    end
    rx_q.push_back(8'($urandom));
    while (exp_tx.size() < rx_q.size()) exp_tx.push_back(8'hFF);
    exp_err.push_back(e);
    last_err = e;
  endtask

  // Byte engine model
  initial begin
    logic [7:0] rx;
    forever begin
      @(negedge cck);
      xfer_done = 1'b0;
      if (xfer_start) begin
        if (abort_at >= 0 && rx_q.size() == abort_at) begin
          reset = 1'b1;
          @(negedge cck);
          chk_idle("reset");
          reset = 1'b0;
          exp_tx.delete(); rx_q.delete(); exp_wr.delete(); exp_err.delete();
          @(negedge cck);
          xfer_rx = 8'hAA; xfer_done = 1'b1;
          @(negedge cck);
          xfer_done = 1'b0;
          repeat (5) @(negedge cck);
          chk_idle("stray");
          aborted = 1'b1;
        end else begin
          if (exp_tx.size() == 0) begin
            checks++; fails++;
            $display("FAIL tx_extra: got %0h expected no exchange", xfer_tx);
          end else check("xfer_tx", xfer_tx, exp_tx.pop_front());
          rx = rx_q.size() ? rx_q.pop_front() : 8'hFF;
          repeat ($urandom_range(0, 3)) begin
            @(negedge cck);
            check("start_outstanding", xfer_start, 0);
          end
          xfer_rx = rx; xfer_done = 1'b1;
        end
      end
    end
  end

  // Output monitor
  initial begin
    logic [16:0] w;
    forever begin
      @(negedge cck);
      if (buf_we) begin
        if (exp_wr.size() == 0) begin
          checks++; fails++;
          $display("FAIL buf_we_extra: got addr %0h expected no write", buf_addr);
        end else begin
          w = exp_wr.pop_front();
          check("buf_addr", buf_addr, w[16:8]);
          check("buf_data", buf_data, w[7:0]);
        end
      end
      if (done) begin
        dones++;
        if (exp_err.size() == 0) begin
          checks++; fails++;
          $display("FAIL done_extra: got done expected none");
        end else check("err", err, exp_err.pop_front());
        check("cs_at_done", cs_assert, 0);
        check("busy_at_done", busy, 1);
      end
    end
  end

  task automatic run(input logic [31:0] l, input logic s, input bit second_go);
    int d0;
    d0 = dones;
    go = 1'b1; lba = l; sdhc = s;
    @(negedge cck);
    go = 1'b0; lba = $urandom; sdhc = ~s;
    check("first_start", xfer_start, 1);
    check("busy_start", busy, 1);
    if (second_go) begin
      repeat (20) @(negedge cck);
      go = 1'b1; lba = 32'hDEADBEEF;
      @(negedge cck);
      go = 1'b0;
    end
    for (int c = 0; c < 30000 && dones == d0 && !(abort_at >= 0 && aborted); c++) @(negedge cck);
    if (abort_at >= 0) begin
      check("abort_seen", aborted, 1);
      check("abort_no_done", dones, d0);
    end else begin
      check("done_count", dones, d0 + 1);
      repeat (3) @(negedge cck);
      check("tx_left", exp_tx.size(), 0);
      check("rx_left", rx_q.size(), 0);
      check("wr_left", exp_wr.size(), 0);
      check("err_held", err, last_err);
      check("cs_idle", cs_assert, 0);
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin
    logic [31:0] l;
    repeat (3) @(negedge cck);
    chk_idle("por");
    reset = 1'b0;
    @(negedge cck);
    build(32'h10, 1, 1, 8'h00, 1, 8'hFE, 0);         run(32'h10, 1, 1);
    build(32'h3, 0, $urandom_range(0, 7), 8'h00, $urandom_range(0, 9), 8'hFE, 1);
    run(32'h3, 0, 0);
    build(32'h1234, 1, R1P, 8'h00, 0, 8'hFE, 1);      run(32'h1234, 1, 0);
    build(32'h55, 1, 2, 8'h04, 0, 8'hFE, 1);          run(32'h55, 1, 0);
    build(32'h77, 0, 0, 8'h00, 2, 8'h05, 1);          run(32'h77, 0, 0);
    build(32'h99, 1, 1, 8'h00, TKP, 8'hFE, 1);        run(32'h99, 1, 0);
    build(32'h10, 1, 1, 8'h00, 1, 8'hFE, 1);
    abort_at = rx_q.size() - 110;
    run(32'h10, 1, 0);
    abort_at = -1;
    build(32'h20, 1, 1, 8'h00, 1, 8'hFE, 1);          run(32'h20, 1, 0);
    for (int t = 0; t < 3; t++) begin
      l = $urandom;
      build(l, t[0], $urandom_range(0, 7), (t == 2) ? 8'($urandom_range(1, 127)) : 8'h00,
            $urandom_range(0, 20), 8'hFE, 1);
      run(l, t[0], 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
